mux4_scan_ctrl: RTL

Sequencer that sits directly upstream of the 4:1 mux (mux4_1): drives its 2-bit select, samples its 1-bit output, and assembles the four channel bits into a 4-bit word.
- Supports single-scan and continuous-scan modes.
- Has a programmable settle delay between select change and sample.
- Reports completion with a one-cycle done pulse and a wrapping scan counter.

---
 rtl/mux4_scan_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps select 0..3, waits SETTLE cycles after
// each select change, samples the mux output, and publishes a 4-bit word.
module mux4_scan_ctrl #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             mux_in,
  output logic [1:0]       select,
  output logic [3:0]       data_out,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] scan_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_t;

  localparam logic [3:0] SET_LD = 4'(SETTLE);
  // With no settle delay a select change goes straight to sampling.
  localparam state_t     FIRST  = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [2:0] shadow;
  logic       launch, step, finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = FIRST;
      S_SETTLE: if (cnt == 4'd1) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (select != 2'd3 || cont) ? FIRST : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    launch = (state == S_IDLE && start) ||
             (state == S_SAMPLE && select == 2'd3 && cont);
    step   = (state == S_SAMPLE) && (select != 2'd3);
    finish = (state == S_SAMPLE) && (select == 2'd3);
    busy   = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      select   <= '0;
      data_out <= '0;
      done     <= 1'b0;
      scan_cnt <= '0;
      cnt      <= '0;
      shadow   <= '0;
    end else begin
      done <= finish;
      if (state == S_SETTLE) cnt <= cnt - 4'd1;
      if (launch) begin
        select <= 2'd0;
        cnt    <= SET_LD;
      end
      if (step) begin
        for (int i = 0; i < 3; i++)
          if (select == 2'(i)) shadow[i] <= mux_in;
        select <= select + 2'd1;
        cnt    <= SET_LD;
      end
      // Word is published whole on the last channel; partial scans never leak.
      if (finish) begin
        data_out <= {mux_in, shadow};
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

endmodule
